led_port_arbiter: RTL and testbench
===================================

LED_PORT_ARBITER -- requirements
Module: led_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, LED output width; TMO_W, default 32, timeout counter width; TMO_RST, default 0, timeout reset value (0 = disabled).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 address_0/_1  in  2  per-core Avalon-MM slave word address.
REQ-005 chipselect_0/_1  in  1  per-core slave select.
REQ-006 write_n_0/_1  in  1  per-core active-low write strobe.
REQ-007 writedata_0/_1  in  32  per-core write data.
REQ-008 readdata_0/_1  out  32  per-core read data; combinational, zero wait states; unused bits 0.
REQ-009 out_port  out  DATA_W  shared LED drive.
REQ-010 owner  out  2  current owner code: 0 none, 1 core 0, 2 core 1.

Function
REQ-011 Each core SHALL see an identical 4-word map: 0 DATA, 1 LOCK, 2 STATUS, 3 TIMEOUT.
REQ-012 DATA write SHALL load writedata[DATA_W-1:0] into out_port at that edge only if the writer is the current owner; a non-owner write SHALL be dropped and SHALL set that core's sticky err bit.
REQ-013 DATA read SHALL return out_port, zero-extended.
REQ-014 LOCK write with bit0=1 SHALL set the writer's req flag; bit0=0 SHALL clear it (release).
REQ-015 LOCK read SHALL return bit0 = req flag and bit1 = granted (owner equals this core).
REQ-016 STATUS read SHALL return bits[1:0] = owner, bit2 = own err, and bit3 = own timeout-revoke flag; a write with bit2 or bit3 = 1 SHALL clear the corresponding sticky bit.
REQ-017 TIMEOUT SHALL be one shared TMO_W register, written by either core and read back by both; if both cores write it in the same cycle, core 0 SHALL win.
REQ-018 FSM states SHALL be IDLE, OWN0 and OWN1; owner is 0/1/2 respectively.
REQ-019 IDLE: if only reqX is set, the next state SHALL be OWNX; if both are set, the next state SHALL be OWN of the core that is not last_owner (last_owner = 1 after reset, so core 0 wins first).
REQ-020 Grant latency: a LOCK request written at edge k SHALL show granted at edge k+1 when the arbiter is idle.
REQ-021 OWNX: when reqX is cleared, the next state SHALL be OWN(other) if the other core's req is set, else IDLE; last_owner SHALL be set to X.
REQ-022 Timeout counter SHALL load TIMEOUT on grant and on each accepted owner DATA write, and SHALL decrement by 1 per cycle otherwise; it SHALL saturate at 0.
REQ-023 When the counter reaches 0 with TIMEOUT != 0, the arbiter SHALL revoke: clear reqX, set X's timeout flag, and follow REQ-021 handover.
REQ-024 TIMEOUT = 0 SHALL disable revocation.
REQ-025 If release and expiry occur in the same cycle, release SHALL take priority and no timeout flag SHALL be set.
REQ-026 If an owner DATA write and expiry occur in the same cycle, the write SHALL be accepted, the counter SHALL reload, and no revoke SHALL occur.
REQ-027 A LOCK=1 write by the current owner SHALL have no effect; a LOCK=0 write by a non-owner SHALL cancel only its pending request.
REQ-028 out_port SHALL hold its value across ownership changes and while IDLE.
REQ-029 A TIMEOUT write SHALL affect the next counter load only, not the running count.

Reset
REQ-030 While reset_n = 0 at a clock edge, the arbiter SHALL set state IDLE, owner 0, out_port 0, req flags 0, err and timeout flags 0, counter 0, TIMEOUT = TMO_RST and last_owner = 1.
REQ-031 Reset asserted mid-ownership SHALL take effect at the next edge, overriding all concurrent writes.

Structure
REQ-032 Package led_arb_pkg SHALL hold the state enum, register address constants, owner codes and STATUS bit positions.
REQ-033 Sub-module led_arb_regif SHALL perform per-core address decode, write strobes and the read mux, and SHALL be instantiated twice; the FSM, counter and shared registers SHALL reside in the top level.

Verification
REQ-034 Reset, core0 LOCK=1 at edge 1 -> owner=1 at edge 2; core0 DATA=0xA5 -> out_port=0xA5.
REQ-035 Core1 DATA=0x3C while core0 owns -> out_port unchanged at 0xA5; core1 STATUS bit2=1; writing 0x4 to STATUS clears it.
REQ-036 Both cores LOCK=1 in the same cycle from IDLE -> core0 granted; core0 releases -> owner=2 next edge; core1 releases and both re-request -> core0 granted.
REQ-037 TIMEOUT=10, core1 granted with no DATA writes -> owner=0 after 10 cycles; core1 STATUS bit3=1; out_port held.
REQ-038 TIMEOUT=5, owner DATA write on the expiry cycle -> no revoke, counter reloads; release coincident with expiry -> timeout flag stays 0.
REQ-039 reset_n=0 for one cycle mid-ownership with a concurrent DATA write -> all registers at reset values, out_port=0.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the two-core LED port arbiter.
// Register map, owner codes, STATUS/LOCK bit positions and the arbiter state enum.
package led_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_LOCK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_CORE0 = 2'd1;
    localparam logic [1:0] OWNER_CORE1 = 2'd2;

    localparam int LOCK_REQ_BIT = 0;
    localparam int LOCK_GNT_BIT = 1;
    localparam int STAT_ERR_BIT = 2;
    localparam int STAT_TMO_BIT = 3;

endpackage

// File: rtl/led_arb_regif.sv
// Per-core register window: address decode into write strobes plus the combinational read mux.
// Zero wait states; never stalls the core.
module led_arb_regif
    import led_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TMO_W  = 32
) (
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] out_port,
    input  logic              req,
    input  logic              granted,
    input  logic              err,
    input  logic              tflag,
    input  logic [1:0]        owner,
    input  logic [TMO_W-1:0]  timeout,
    output logic              wr_data,
    output logic              wr_lock,
    output logic              wr_status,
    output logic              wr_tmo,
    output logic [31:0]       readdata
);

    logic we;
    assign we        = chipselect && !write_n;
    assign wr_data   = we && (address == ADDR_DATA);
    assign wr_lock   = we && (address == ADDR_LOCK);
    assign wr_status = we && (address == ADDR_STATUS);
    assign wr_tmo    = we && (address == ADDR_TIMEOUT);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(out_port);
            ADDR_LOCK: begin
                readdata[LOCK_REQ_BIT] = req;
                readdata[LOCK_GNT_BIT] = granted;
            end
            ADDR_STATUS: begin
                readdata[1:0]          = owner;
                readdata[STAT_ERR_BIT] = err;
                readdata[STAT_TMO_BIT] = tflag;
            end
            default:      readdata = 32'(timeout);
        endcase
    end

endmodule

// File: rtl/led_port_arbiter.sv
// Two Avalon-MM cores share one LED port through a lock/grant FSM with optional ownership timeout.
// Grant one cycle after the request is registered; non-owner data writes are dropped and flagged.
module led_port_arbiter
    import led_arb_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter int              TMO_W   = 32,
    parameter logic [TMO_W-1:0] TMO_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address_0,
    input  logic              chipselect_0,
    input  logic              write_n_0,
    input  logic [31:0]       writedata_0,
    output logic [31:0]       readdata_0,
    input  logic [1:0]        address_1,
    input  logic              chipselect_1,
    input  logic              write_n_1,
    input  logic [31:0]       writedata_1,
    output logic [31:0]       readdata_1,
    output logic [DATA_W-1:0] out_port,
    output logic [1:0]        owner
);

    arb_state_e       state, state_nxt;
    logic             last_owner, last_owner_nxt;
    logic [1:0]       req, err, tflag, own_vec;
    logic [1:0]       wr_data, wr_lock, wr_status, wr_tmo;
    logic [31:0]      wdat [2];
    logic [TMO_W-1:0] tmo, cnt;
    logic             cur, accept, rel_wr, expire, revoke, grant;

    assign wdat[0] = writedata_0;
    assign wdat[1] = writedata_1;

    led_arb_regif #(.DATA_W(DATA_W), .TMO_W(TMO_W)) u_regif0 (
        .address(address_0), .chipselect(chipselect_0), .write_n(write_n_0),
        .out_port(out_port), .req(req[0]), .granted(own_vec[0]), .err(err[0]),
        .tflag(tflag[0]), .owner(owner), .timeout(tmo),
        .wr_data(wr_data[0]), .wr_lock(wr_lock[0]), .wr_status(wr_status[0]),
        .wr_tmo(wr_tmo[0]), .readdata(readdata_0)
    );

    led_arb_regif #(.DATA_W(DATA_W), .TMO_W(TMO_W)) u_regif1 (
        .address(address_1), .chipselect(chipselect_1), .write_n(write_n_1),
        .out_port(out_port), .req(req[1]), .granted(own_vec[1]), .err(err[1]),
        .tflag(tflag[1]), .owner(owner), .timeout(tmo),
        .wr_data(wr_data[1]), .wr_lock(wr_lock[1]), .wr_status(wr_status[1]),
        .wr_tmo(wr_tmo[1]), .readdata(readdata_1)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // A release write in flight counts as a release, so it beats a simultaneous expiry.
    assign rel_wr = wr_lock[cur] && !wdat[cur][0];
    assign expire = (tmo != '0) && (cnt <= TMO_W'(1));
    assign accept = |(wr_data & own_vec);

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        revoke         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req == 2'b11)  state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
                else if (req[0])   state_nxt = ST_OWN0;
                else if (req[1])   state_nxt = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!req[cur] || (expire && !rel_wr && !wr_data[cur])) begin
                    revoke         = req[cur];
                    last_owner_nxt = cur;
                    if (req[!cur]) state_nxt = cur ? ST_OWN0 : ST_OWN1;
                    else           state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign grant = (state_nxt != ST_IDLE) && (state_nxt != state);

    always_comb begin
        owner   = OWNER_NONE;
        own_vec = 2'b00;
        case (state)
            ST_OWN0: begin owner = OWNER_CORE0; own_vec = 2'b01; end
            ST_OWN1: begin owner = OWNER_CORE1; own_vec = 2'b10; end
            default: ;
        endcase
    end
    assign cur = own_vec[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req      <= '0;
            err      <= '0;
            tflag    <= '0;
            out_port <= '0;
            tmo      <= TMO_RST;
            cnt      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_lock[i])                          req[i]   <= wdat[i][0];
                if (revoke && (cur == i[0]))             req[i]   <= 1'b0;
                if (wr_status[i] && wdat[i][STAT_ERR_BIT]) err[i] <= 1'b0;
                if (wr_data[i] && !own_vec[i])           err[i]   <= 1'b1;
                if (wr_status[i] && wdat[i][STAT_TMO_BIT]) tflag[i] <= 1'b0;
                if (revoke && (cur == i[0]))             tflag[i] <= 1'b1;
            end
            if (accept)         out_port <= wdat[cur][DATA_W-1:0];
            if (wr_tmo[0])      tmo <= wdat[0][TMO_W-1:0];
            else if (wr_tmo[1]) tmo <= wdat[1][TMO_W-1:0];
            // Loads use the settled TIMEOUT value; a same-cycle write only affects later loads.
            if (grant || accept)  cnt <= tmo;
            else if (cnt != '0)   cnt <= cnt - TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_led_port_arbiter.sv
// Directed bench for led_port_arbiter: lock/grant, fairness, error and timeout flags, reset.
module tb_led_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address_0, address_1;
    logic        chipselect_0, chipselect_1;
    logic        write_n_0, write_n_1;
    logic [31:0] writedata_0, writedata_1;
    logic [31:0] readdata_0, readdata_1;
    logic [7:0]  out_port;
    logic [1:0]  owner;
    logic [31:0] rv;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    led_port_arbiter #(.DATA_W(8), .TMO_W(32), .TMO_RST(32'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .address_0(address_0), .chipselect_0(chipselect_0), .write_n_0(write_n_0),
        .writedata_0(writedata_0), .readdata_0(readdata_0),
        .address_1(address_1), .chipselect_1(chipselect_1), .write_n_1(write_n_1),
        .writedata_1(writedata_1), .readdata_1(readdata_1),
        .out_port(out_port), .owner(owner)
    );

    task automatic idle_bus();
        address_0 = 2'd0; chipselect_0 = 1'b0; write_n_0 = 1'b1; writedata_0 = '0;
        address_1 = 2'd0; chipselect_1 = 1'b0; write_n_1 = 1'b1; writedata_1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wr(input int c, input logic [1:0] a, input logic [31:0] d);
        if (c == 0) begin
            address_0 = a; chipselect_0 = 1'b1; write_n_0 = 1'b0; writedata_0 = d;
        end else begin
            address_1 = a; chipselect_1 = 1'b1; write_n_1 = 1'b0; writedata_1 = d;
        end
    endtask

    task automatic rd(input int c, input logic [1:0] a, output logic [31:0] v);
        if (c == 0) begin
            address_0 = a; chipselect_0 = 1'b1; write_n_0 = 1'b1;
            #1 v = readdata_0;
        end else begin
            address_1 = a; chipselect_1 = 1'b1; write_n_1 = 1'b1;
            #1 v = readdata_1;
        end
        idle_bus();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle_bus();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_out", 32'(out_port), 32'd0);
        rd(0, 2'd3, rv); chk("rst_timeout", rv, 32'd0);
        rd(1, 2'd2, rv); chk("rst_status1", rv, 32'd0);

        // Grant latency from idle
        wr(0, 2'd1, 32'd1); tick();
        chk("req_not_yet_owner", 32'(owner), 32'd0);
        rd(0, 2'd1, rv); chk("lock0_pending", rv, 32'd1);
        tick();
        chk("grant0_owner", 32'(owner), 32'd1);
        rd(0, 2'd1, rv); chk("lock0_granted", rv, 32'd3);
        wr(0, 2'd0, 32'hA5); tick();
        chk("data0_out", 32'(out_port), 32'hA5);

        // Non-owner write dropped and flagged, then cleared
        wr(1, 2'd0, 32'h3C); tick();
        chk("nonowner_out", 32'(out_port), 32'hA5);
        rd(1, 2'd2, rv); chk("status1_err", rv, 32'h5);
        rd(0, 2'd2, rv); chk("status0_clean", rv, 32'h1);
        wr(1, 2'd2, 32'h4); tick();
        rd(1, 2'd2, rv); chk("status1_errclr", rv, 32'h1);

        // Pending request, handover on release
        wr(1, 2'd1, 32'd1); tick();
        rd(1, 2'd1, rv); chk("lock1_pending", rv, 32'd1);
        wr(0, 2'd1, 32'd0); tick(); tick();
        chk("handover_owner", 32'(owner), 32'd2);
        chk("handover_out_held", 32'(out_port), 32'hA5);
        wr(1, 2'd1, 32'd0); tick(); tick();
        chk("idle_owner", 32'(owner), 32'd0);
        chk("idle_out_held", 32'(out_port), 32'hA5);

        // Simultaneous requests, last_owner=1 -> core0
        wr(0, 2'd1, 32'd1); wr(1, 2'd1, 32'd1); tick(); tick();
        chk("both_core0_wins", 32'(owner), 32'd1);
        wr(0, 2'd1, 32'd0); tick(); tick();
        chk("release_to_core1", 32'(owner), 32'd2);
        wr(1, 2'd1, 32'd0); tick(); tick();
        wr(0, 2'd1, 32'd1); wr(1, 2'd1, 32'd1); tick(); tick();
        chk("rerequest_core0", 32'(owner), 32'd1);
        wr(0, 2'd1, 32'd0); wr(1, 2'd1, 32'd0); tick(); tick();
        chk("both_release_idle", 32'(owner), 32'd0);

        // Timeout revoke: last_owner=0 so core1 wins, core0 cancels pending request
        wr(0, 2'd3, 32'd10); tick();
        rd(1, 2'd3, rv); chk("timeout_shared", rv, 32'd10);
        wr(0, 2'd1, 32'd1); wr(1, 2'd1, 32'd1); tick(); tick();
        chk("both_core1_wins", 32'(owner), 32'd2);
        wr(0, 2'd1, 32'd0); tick();
        rd(0, 2'd1, rv); chk("cancel_pending", rv, 32'd0);
        chk("cancel_keeps_owner", 32'(owner), 32'd2);
        repeat (8) tick();
        chk("pre_expiry_owner", 32'(owner), 32'd2);
        tick();
        chk("revoked_owner", 32'(owner), 32'd0);
        rd(1, 2'd2, rv); chk("status1_tflag", rv, 32'h8);
        rd(0, 2'd2, rv); chk("status0_no_tflag", rv, 32'h0);
        rd(1, 2'd1, rv); chk("lock1_cleared", rv, 32'd0);
        chk("revoke_out_held", 32'(out_port), 32'hA5);
        wr(1, 2'd2, 32'h8); tick();
        rd(1, 2'd2, rv); chk("status1_tflag_clr", rv, 32'h0);

        // Data write on expiry cycle reloads; release on expiry cycle sets no flag
        wr(1, 2'd3, 32'd5); tick();
        rd(0, 2'd3, rv); chk("timeout5", rv, 32'd5);
        wr(0, 2'd1, 32'd1); tick(); tick();
        chk("grant0_t5", 32'(owner), 32'd1);
        repeat (4) tick();
        wr(0, 2'd0, 32'h5A); tick();
        chk("expiry_write_out", 32'(out_port), 32'h5A);
        chk("expiry_write_owner", 32'(owner), 32'd1);
        repeat (4) tick();
        chk("reload_owner", 32'(owner), 32'd1);
        wr(0, 2'd1, 32'd0); tick();
        rd(0, 2'd2, rv); chk("release_expiry_status", rv, 32'h1);
        tick();
        chk("release_expiry_idle", 32'(owner), 32'd0);
        rd(0, 2'd2, rv); chk("release_no_tflag", rv, 32'h0);

        // Reset mid-ownership overrides concurrent writes
        wr(0, 2'd1, 32'd1); tick(); tick();
        chk("grant_before_rst", 32'(owner), 32'd1);
        reset_n = 1'b0;
        wr(0, 2'd0, 32'hFF); wr(1, 2'd3, 32'd99);
        tick();
        reset_n = 1'b1;
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_out", 32'(out_port), 32'd0);
        rd(0, 2'd3, rv); chk("mid_rst_timeout", rv, 32'd0);
        rd(0, 2'd1, rv); chk("mid_rst_lock0", rv, 32'd0);
        wr(0, 2'd1, 32'd1); wr(1, 2'd1, 32'd1); tick(); tick();
        chk("mid_rst_last_owner", 32'(owner), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
